// File: rtl/cpcs_rx_sync_if.sv
// Code-group stream and sync status bundle between the 8b/10b receive decode logic
// and the code-group synchronization controller.
interface cpcs_rx_sync_if #(
  parameter int CNT_W = 16
);
  logic             CG_VALID;
  logic             COMMA;
  logic             CERR;
  logic             PD6BU;
  logic             ND6BU;
  logic             PD4BU;
  logic             ND4BU;
  logic             PD6BC;
  logic             ND6BC;
  logic             PD4BC;
  logic             ND4BC;
  logic             CNT_CLR;
  logic             SYNC_OK;
  logic             RX_EVEN;
  logic             RD_POS;
  logic             DISP_ERR;
  logic             CG_BAD;
  logic [3:0]       STATE;
  logic [CNT_W-1:0] CERR_CNT;
  logic [CNT_W-1:0] DISP_CNT;
  logic [CNT_W-1:0] LOSS_CNT;

  modport master (
    output CG_VALID, COMMA, CERR,
    output PD6BU, ND6BU, PD4BU, ND4BU,
    output PD6BC, ND6BC, PD4BC, ND4BC,
    output CNT_CLR,
    input  SYNC_OK, RX_EVEN, RD_POS, DISP_ERR, CG_BAD, STATE,
    input  CERR_CNT, DISP_CNT, LOSS_CNT
  );

  modport slave (
    input  CG_VALID, COMMA, CERR,
    input  PD6BU, ND6BU, PD4BU, ND4BU,
    input  PD6BC, ND6BC, PD4BC, ND4BC,
    input  CNT_CLR,
    output SYNC_OK, RX_EVEN, RD_POS, DISP_ERR, CG_BAD, STATE,
    output CERR_CNT, DISP_CNT, LOSS_CNT
  );
endinterface

// File: rtl/cpcs_rx_sync.sv
// Receive code-group synchronization: running disparity tracking, disparity error
// detection, acquire/lose sync FSM with even/odd tracking, and saturating statistics.
module cpcs_rx_sync #(
  parameter int CNT_W    = 16,
  parameter int GOOD_RUN = 4
) (
  input  logic           RX_CLK,
  input  logic           RESET_N,
  cpcs_rx_sync_if.slave  bus
);

  typedef enum logic [3:0] {
    LOS  = 4'd0,
    CD1  = 4'd1,
    ACQ1 = 4'd2,
    CD2  = 4'd3,
    ACQ2 = 4'd4,
    CD3  = 4'd5,
    SA1  = 4'd6,
    SA2  = 4'd7,
    SA3  = 4'd8,
    SA4  = 4'd9
  } sync_state_t;

  localparam int GW = (GOOD_RUN < 2) ? 1 : $clog2(GOOD_RUN + 1);

  sync_state_t   state_reg;
  logic          sync_ok_reg;
  logic          rx_even_reg;
  logic          rd_pos_reg;
  logic          disp_err_reg;
  logic          cg_bad_reg;
  logic [GW-1:0] good_cnt_reg;

  logic          rd_mid;
  logic          rd_next;
  logic          err_6b;
  logic          err_4b;
  logic          disp_err_now;
  logic          cg_bad_now;
  logic          even_now;
  logic          odd_comma;
  logic          sa_bad;
  logic [GW-1:0] good_cnt_inc;
  logic          good_done;

  // The 4b sub-block is judged against the disparity left by the 6b sub-block.
  assign rd_mid       = bus.PD6BU ? 1'b1 : (bus.ND6BU ? 1'b0 : rd_pos_reg);
  assign rd_next      = bus.PD4BU ? 1'b1 : (bus.ND4BU ? 1'b0 : rd_mid);
  assign err_6b       = (!rd_pos_reg & bus.PD6BC) | (rd_pos_reg & bus.ND6BC);
  assign err_4b       = (!rd_mid & bus.PD4BC) | (rd_mid & bus.ND4BC);
  assign disp_err_now = err_6b | err_4b;
  assign cg_bad_now   = bus.CERR | disp_err_now;

  assign even_now     = !rx_even_reg;
  assign odd_comma    = bus.COMMA & !even_now;
  assign sa_bad       = cg_bad_now | odd_comma;

  assign good_cnt_inc = good_cnt_reg + GW'(1);
  assign good_done    = (good_cnt_inc == GW'(GOOD_RUN));

  always_ff @(posedge RX_CLK) begin
    if (!RESET_N) begin
      state_reg    <= LOS;
      sync_ok_reg  <= 1'b0;
      rx_even_reg  <= 1'b0;
      rd_pos_reg   <= 1'b0;
      disp_err_reg <= 1'b0;
      cg_bad_reg   <= 1'b0;
      good_cnt_reg <= '0;
    end else if (bus.CG_VALID) begin
      rd_pos_reg   <= rd_next;
      disp_err_reg <= disp_err_now;
      cg_bad_reg   <= cg_bad_now;
      rx_even_reg  <= even_now;

      case (state_reg)
        LOS: begin
          // Any comma restarts detection here; odd position is not yet meaningful.
          if (bus.COMMA && !cg_bad_now) begin
            state_reg   <= CD1;
            rx_even_reg <= 1'b1;
          end
        end

        CD1: begin
          if (cg_bad_now) begin
            state_reg <= LOS;
          end else begin
            state_reg   <= ACQ1;
            rx_even_reg <= 1'b0;
          end
        end

        CD2: begin
          if (cg_bad_now) begin
            state_reg <= LOS;
          end else begin
            state_reg   <= ACQ2;
            rx_even_reg <= 1'b0;
          end
        end

        CD3: begin
          if (cg_bad_now) begin
            state_reg <= LOS;
          end else begin
            state_reg   <= SA1;
            sync_ok_reg <= 1'b1;
            rx_even_reg <= 1'b0;
          end
        end

        ACQ1: begin
          if (cg_bad_now || odd_comma) begin
            state_reg <= LOS;
          end else if (bus.COMMA && even_now) begin
            state_reg <= CD2;
          end
        end

        ACQ2: begin
          if (cg_bad_now || odd_comma) begin
            state_reg <= LOS;
          end else if (bus.COMMA && even_now) begin
            state_reg <= CD3;
          end
        end

        SA1: begin
          if (sa_bad) begin
            state_reg    <= SA2;
            good_cnt_reg <= '0;
          end
        end

        SA2: begin
          if (sa_bad) begin
            state_reg    <= SA3;
            good_cnt_reg <= '0;
          end else if (good_done) begin
            state_reg    <= SA1;
            good_cnt_reg <= '0;
          end else begin
            good_cnt_reg <= good_cnt_inc;
          end
        end

        SA3: begin
          if (sa_bad) begin
            state_reg    <= SA4;
            good_cnt_reg <= '0;
          end else if (good_done) begin
            state_reg    <= SA2;
            good_cnt_reg <= '0;
          end else begin
            good_cnt_reg <= good_cnt_inc;
          end
        end

        SA4: begin
          if (sa_bad) begin
            state_reg    <= LOS;
            sync_ok_reg  <= 1'b0;
            good_cnt_reg <= '0;
          end else if (good_done) begin
            state_reg    <= SA3;
            good_cnt_reg <= '0;
          end else begin
            good_cnt_reg <= good_cnt_inc;
          end
        end

        default: begin
          state_reg    <= LOS;
          sync_ok_reg  <= 1'b0;
          good_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Statistics: index 0 = code violations, 1 = disparity errors, 2 = sync losses.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [3];

  assign cnt_inc[0] = bus.CG_VALID & bus.CERR;
  assign cnt_inc[1] = bus.CG_VALID & disp_err_now;
  assign cnt_inc[2] = bus.CG_VALID & (state_reg == SA4) & sa_bad;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge RX_CLK) begin
        if (!RESET_N) begin
          cnt_reg <= '0;
        end else if (bus.CNT_CLR) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign bus.STATE    = state_reg;
  assign bus.SYNC_OK  = sync_ok_reg;
  assign bus.RX_EVEN  = rx_even_reg;
  assign bus.RD_POS   = rd_pos_reg;
  assign bus.DISP_ERR = disp_err_reg;
  assign bus.CG_BAD   = cg_bad_reg;
  assign bus.CERR_CNT = cnt_q[0];
  assign bus.DISP_CNT = cnt_q[1];
  assign bus.LOSS_CNT = cnt_q[2];

endmodule

// File: tb/tb_cpcs_rx_sync.sv
// Self-checking bench for cpcs_rx_sync: directed sync scenarios followed by random
// code-group traffic, checked against a level-based behavioural model.
module tb_cpcs_rx_sync;

  localparam int CNT_W    = 16;
  localparam int CNT_W2   = 2;
  localparam int GOOD_RUN = 4;

  // Flag vector layout {PD6BU, ND6BU, PD4BU, ND4BU, PD6BC, ND6BC, PD4BC, ND4BC}
  localparam bit [7:0] F_PD6U = 8'h80;
  localparam bit [7:0] F_ND6U = 8'h40;
  localparam bit [7:0] F_PD6C = 8'h08;
  localparam bit [7:0] F_ND6C = 8'h04;
  localparam bit [7:0] F_PD4C = 8'h02;
  localparam bit [7:0] F_ND4C = 8'h01;

  localparam int K_LOS = 0;
  localparam int K_CD  = 1;
  localparam int K_ACQ = 2;
  localparam int K_SA  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cg_valid = 1'b0;
  logic       comma = 1'b0;
  logic       cerr = 1'b0;
  logic [7:0] flags = 8'h00;
  logic       cnt_clr = 1'b0;

  always #5 clk = ~clk;

  cpcs_rx_sync_if #(.CNT_W(CNT_W))  bus ();
  cpcs_rx_sync_if #(.CNT_W(CNT_W2)) bus2 ();

  assign bus.CG_VALID  = cg_valid;
  assign bus.COMMA     = comma;
  assign bus.CERR      = cerr;
  assign bus.PD6BU     = flags[7];
  assign bus.ND6BU     = flags[6];
  assign bus.PD4BU     = flags[5];
  assign bus.ND4BU     = flags[4];
  assign bus.PD6BC     = flags[3];
  assign bus.ND6BC     = flags[2];
  assign bus.PD4BC     = flags[1];
  assign bus.ND4BC     = flags[0];
  assign bus.CNT_CLR   = cnt_clr;
  assign bus2.CG_VALID = cg_valid;
  assign bus2.COMMA    = comma;
  assign bus2.CERR     = cerr;
  assign bus2.PD6BU    = flags[7];
  assign bus2.ND6BU    = flags[6];
  assign bus2.PD4BU    = flags[5];
  assign bus2.ND4BU    = flags[4];
  assign bus2.PD6BC    = flags[3];
  assign bus2.ND6BC    = flags[2];
  assign bus2.PD4BC    = flags[1];
  assign bus2.ND4BC    = flags[0];
  assign bus2.CNT_CLR  = cnt_clr;

  cpcs_rx_sync #(.CNT_W(CNT_W), .GOOD_RUN(GOOD_RUN)) dut (
    .RX_CLK (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  cpcs_rx_sync #(.CNT_W(CNT_W2), .GOOD_RUN(GOOD_RUN)) dut2 (
    .RX_CLK (clk),
    .RESET_N(rst_n),
    .bus    (bus2)
  );

  // Model: sync progress as a phase (LOS / detect / acquire / synced) plus a level.
  int     m_kind;
  int     m_lvl;
  int     m_good;
  bit     m_even;
  bit     m_rd;
  bit     m_derr;
  bit     m_bad;
  longint m_ncerr;
  longint m_ndisp;
  longint m_nloss;

  int n_assert = 0;
  int n_fail   = 0;
  int n_grp    = 0;

  function automatic int enc_state();
    case (m_kind)
      K_CD:    return 2 * m_lvl - 1;
      K_ACQ:   return 2 * m_lvl;
      K_SA:    return 5 + m_lvl;
      default: return 0;
    endcase
  endfunction

  function automatic longint sat(input longint n, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return (n > top) ? top : n;
  endfunction

  task automatic model_reset();
    m_kind = K_LOS; m_lvl = 0; m_good = 0; m_even = 0; m_rd = 0;
    m_derr = 0; m_bad = 0; m_ncerr = 0; m_ndisp = 0; m_nloss = 0;
  endtask

  task automatic model_step();
    bit rd_mid, err, bad, e, oddc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (cg_valid) begin
      rd_mid = flags[7] ? 1'b1 : (flags[6] ? 1'b0 : m_rd);
      err    = (!m_rd & flags[3]) | (m_rd & flags[2]) | (!rd_mid & flags[1]) | (rd_mid & flags[0]);
      m_rd   = flags[5] ? 1'b1 : (flags[4] ? 1'b0 : rd_mid);
      bad    = cerr | err;
      e      = !m_even;
      oddc   = comma & !e;
      m_derr = err;
      m_bad  = bad;
      if (cerr) m_ncerr++;
      if (err)  m_ndisp++;
      case (m_kind)
        K_LOS: begin
          if (comma && !bad) begin m_kind = K_CD; m_lvl = 1; m_even = 1; end
          else m_even = e;
        end
        K_CD: begin
          if (bad) begin m_kind = K_LOS; m_even = e; end
          else begin
            m_even = 0;
            if (m_lvl == 3) begin m_kind = K_SA; m_lvl = 1; end
            else m_kind = K_ACQ;
          end
        end
        K_ACQ: begin
          m_even = e;
          if (bad || oddc) m_kind = K_LOS;
          else if (comma && e) begin m_kind = K_CD; m_lvl = m_lvl + 1; end
        end
        default: begin
          m_even = e;
          if (bad || oddc) begin
            m_good = 0;
            if (m_lvl == 4) begin m_kind = K_LOS; m_nloss++; end
            else m_lvl++;
          end else if (m_lvl > 1) begin
            m_good++;
            if (m_good == GOOD_RUN) begin m_lvl--; m_good = 0; end
          end
        end
      endcase
    end
    if (cnt_clr) begin
      m_ncerr = 0; m_ndisp = 0; m_nloss = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (grp %0d): observed %0d expected %0d", tag, n_grp, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",     64'(bus.STATE),    64'(enc_state()));
    chk("sync_ok",   64'(bus.SYNC_OK),  64'(m_kind == K_SA));
    chk("rx_even",   64'(bus.RX_EVEN),  64'(m_even));
    chk("rd_pos",    64'(bus.RD_POS),   64'(m_rd));
    chk("disp_err",  64'(bus.DISP_ERR), 64'(m_derr));
    chk("cg_bad",    64'(bus.CG_BAD),   64'(m_bad));
    chk("cerr_cnt",  64'(bus.CERR_CNT), 64'(sat(m_ncerr, CNT_W)));
    chk("disp_cnt",  64'(bus.DISP_CNT), 64'(sat(m_ndisp, CNT_W)));
    chk("loss_cnt",  64'(bus.LOSS_CNT), 64'(sat(m_nloss, CNT_W)));
    chk("state_w2",  64'(bus2.STATE),    64'(enc_state()));
    chk("cerr_cnt2", 64'(bus2.CERR_CNT), 64'(sat(m_ncerr, CNT_W2)));
    chk("disp_cnt2", 64'(bus2.DISP_CNT), 64'(sat(m_ndisp, CNT_W2)));
    chk("loss_cnt2", 64'(bus2.LOSS_CNT), 64'(sat(m_nloss, CNT_W2)));
  endtask

  task automatic grp(input bit v, input bit c, input bit ce, input bit [7:0] f, input bit clr);
    cg_valid = v; comma = c; cerr = ce; flags = f; cnt_clr = clr;
    @(posedge clk);
    #1;
    n_grp++;
    model_step();
    $display("grp %0d rst_n=%0b v=%0b comma=%0b cerr=%0b flags=%02h clr=%0b -> state=%0d sync=%0b even=%0b rd=%0b derr=%0b cerr_cnt=%0d",
             n_grp, rst_n, v, c, ce, f, clr, bus.STATE, bus.SYNC_OK, bus.RX_EVEN, bus.RD_POS,
             bus.DISP_ERR, bus.CERR_CNT);
    check_all();
  endtask

  // K28.5 and D16.2 in the column matching the current running disparity.
  task automatic k285();
    if (!m_rd) grp(1, 1, 0, F_PD6U | F_ND6C | F_PD4C, 0);
    else       grp(1, 1, 0, F_ND6U | F_PD6C | F_ND4C, 0);
  endtask

  task automatic d162();
    if (m_rd) grp(1, 0, 0, F_ND6U | F_PD6C, 0);
    else      grp(1, 0, 0, F_PD6U | F_ND6C, 0);
  endtask

  task automatic neutral();
    grp(1, 0, 0, 8'h00, 0);
  endtask

  task automatic wrong_column();
    if (!m_rd) grp(1, 0, 0, F_ND6U | F_PD6C, 0);
    else       grp(1, 0, 0, F_PD6U | F_ND6C, 0);
  endtask

  initial begin
    int   exp_walk [6];
    int   snap_state;
    bit   snap_even, snap_rd;
    logic [7:0] f;
    bit   v, c, ce, clr;

    exp_walk = '{1, 2, 3, 4, 5, 6};
    model_reset();

    // Reset
    rst_n = 1'b0;
    grp(0, 0, 0, 8'h00, 0);
    grp(1, 1, 1, 8'hff, 0);
    chk("rst_state",   64'(bus.STATE),    64'd0);
    chk("rst_sync_ok", 64'(bus.SYNC_OK),  64'd0);
    chk("rst_cerr",    64'(bus.CERR_CNT), 64'd0);
    rst_n = 1'b1;

    // Acquire: three K28.5 / D16.2 pairs
    for (int i = 0; i < 3; i++) begin
      k285();
      chk("walk_k", 64'(bus.STATE), 64'(exp_walk[2*i]));
      d162();
      chk("walk_d", 64'(bus.STATE), 64'(exp_walk[2*i+1]));
      chk("walk_derr", 64'(bus.DISP_ERR), 64'd0);
    end
    chk("acq_sync_ok", 64'(bus.SYNC_OK), 64'd1);
    chk("acq_rd_pos",  64'(bus.RD_POS),  64'd0);

    // Disparity error in SA1, then recovery after GOOD_RUN good groups
    wrong_column();
    chk("derr_flag",  64'(bus.DISP_ERR), 64'd1);
    chk("derr_state", 64'(bus.STATE),    64'd7);
    chk("derr_cnt",   64'(bus.DISP_CNT), 64'd1);
    for (int i = 0; i < GOOD_RUN; i++) neutral();
    chk("recover_sa1", 64'(bus.STATE), 64'd6);

    // Four spaced CERR groups walk down to LOS
    for (int i = 0; i < 4; i++) begin
      grp(1, 0, 1, 8'h00, 0);
      chk("cerr_walk", 64'(bus.STATE), 64'((i == 3) ? 0 : 7 + i));
      if (i < 3) begin
        for (int j = 0; j < 3; j++) neutral();
      end
    end
    chk("loss_sync_ok", 64'(bus.SYNC_OK),  64'd0);
    chk("loss_cnt_1",   64'(bus.LOSS_CNT), 64'd1);

    // Odd comma while in ACQ1
    k285();
    d162();
    chk("in_acq1", 64'(bus.STATE), 64'd2);
    neutral();
    chk("odd_pos", 64'(bus.RX_EVEN), 64'd1);
    k285();
    chk("oddc_los", 64'(bus.STATE), 64'd0);

    // Idle mid-acquisition, then clear racing a CERR
    k285();
    d162();
    snap_state = enc_state();
    snap_even  = m_even;
    snap_rd    = m_rd;
    for (int i = 0; i < 10; i++) begin
      grp(0, 1'($urandom), 1'($urandom), 8'($urandom), 0);
      chk("idle_state", 64'(bus.STATE),   64'(snap_state));
      chk("idle_even",  64'(bus.RX_EVEN), 64'(snap_even));
      chk("idle_rd",    64'(bus.RD_POS),  64'(snap_rd));
    end
    grp(1, 0, 1, 8'h00, 1);
    chk("clr_cerr", 64'(bus.CERR_CNT), 64'd0);

    // Saturation of the narrow counters
    for (int i = 0; i < 5; i++) grp(1, 0, 1, 8'h00, 0);
    chk("sat_cerr_w2",  64'(bus2.CERR_CNT), 64'd3);
    chk("sat_cerr_w16", 64'(bus.CERR_CNT),  64'd5);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 99) < 88);
      c   = (m_even == 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 8);
      ce  = ($urandom_range(0, 99) < 2);
      clr = ($urandom_range(0, 199) < 2);
      for (int b = 4; b < 8; b++) f[b] = ($urandom_range(0, 99) < 25);
      for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, 99) < 3);
      rst_n = ($urandom_range(0, 499) != 0);
      grp(v, c, ce, f, clr);
      rst_n = 1'b1;
    end

    // Reset while in SA2
    grp(1, 0, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      k285();
      d162();
    end
    wrong_column();
    chk("pre_rst_sa2", 64'(bus.STATE), 64'd7);
    rst_n = 1'b0;
    grp(1, 1, 1, 8'hff, 0);
    chk("mid_rst_state",   64'(bus.STATE),    64'd0);
    chk("mid_rst_sync_ok", 64'(bus.SYNC_OK),  64'd0);
    chk("mid_rst_derr",    64'(bus.DISP_ERR), 64'd0);
    chk("mid_rst_cgbad",   64'(bus.CG_BAD),   64'd0);
    chk("mid_rst_dcnt",    64'(bus.DISP_CNT), 64'd0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
